// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction fetch stage.
//   FETCH_XLEN    : default data/address width of the fetch path.
//   INSTR_BYTES   : bytes per instruction at the default width.
//   fetch_entry_t : one fetch-queue entry {pc, next_pc, instr} at the default
//                   width. instr_fetch_buf declares an XLEN-sized equivalent
//                   and hands it to fetch_fifo as a type parameter.
// -----------------------------------------------------------------------------
package fetch_pkg;

   localparam int unsigned FETCH_XLEN  = 32;
   localparam int unsigned INSTR_BYTES = FETCH_XLEN / 8;

   typedef struct packed {
      logic [FETCH_XLEN-1:0] pc;
      logic [FETCH_XLEN-1:0] next_pc;
      logic [FETCH_XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// -----------------------------------------------------------------------------
// fetch_fifo
// Synchronous FIFO of fetch entries with a registered head.
// Ports:
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   push, push_data: write request and entry (ignored when full without pop)
//   pop            : remove the head (ignored when empty)
//   flush          : empty the queue; wins over push in the same cycle
//   full, empty    : queue status
//   occupancy      : number of stored entries (0..DEPTH)
//   head_valid     : registered "queue not empty"
//   head_data      : registered copy of the current head entry
// A push into an empty queue (or one emptied by a same-cycle pop) is visible
// on head_valid/head_data in the following cycle.
// -----------------------------------------------------------------------------
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter type         entry_t = fetch_entry_t,
   parameter int unsigned DEPTH   = 4
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push,
   input  entry_t                     push_data,
   input  logic                       pop,
   input  logic                       flush,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] occupancy,
   output logic                       head_valid,
   output entry_t                     head_data
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH+1);

   entry_t        mem [DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr, rd_ptr_n, wr_ptr_n;
   logic [CW-1:0] count, count_n;
   logic          pop_ok, push_ok, head_valid_n;
   entry_t        head_data_n;

   assign full      = (count == CW'(DEPTH));
   assign empty     = (count == '0);
   assign occupancy = count;
   assign pop_ok    = pop & ~empty;
   // When full, a same-cycle pop frees the slot the push lands in.
   assign push_ok   = push & (~full | pop_ok);

   always_comb begin
      rd_ptr_n     = rd_ptr + AW'(pop_ok);
      wr_ptr_n     = wr_ptr + AW'(push_ok);
      count_n      = count + CW'(push_ok) - CW'(pop_ok);
      head_valid_n = (count_n != '0);
      head_data_n  = head_data;
      if (head_valid_n) begin
         // The entry being written this cycle becomes the head only when the
         // queue is empty after this cycle's pop; memory is not yet updated.
         if (push_ok && ((count - CW'(pop_ok)) == '0))
            head_data_n = push_data;
         else
            head_data_n = mem[rd_ptr_n];
      end
      if (flush) begin
         rd_ptr_n     = '0;
         wr_ptr_n     = '0;
         count_n      = '0;
         head_valid_n = 1'b0;
         head_data_n  = head_data;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok && !flush)
         mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         head_valid <= 1'b0;
         head_data  <= '0;
      end else begin
         rd_ptr     <= rd_ptr_n;
         wr_ptr     <= wr_ptr_n;
         count      <= count_n;
         head_valid <= head_valid_n;
         head_data  <= head_data_n;
      end
   end

endmodule

// File: rtl/instr_fetch_buf.sv
// -----------------------------------------------------------------------------
// instr_fetch_buf
// Instruction fetch stage between the program memory port and the decoder.
// Issues sequential reads with up to MAX_OUTSTANDING requests in flight,
// buffers in-order responses in a DEPTH-entry queue and presents the head to
// the decoder over valid/ready. A branch redirect flushes the queue and
// discards every response still owed for pre-branch requests.
// Ports:
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   boot_addr_i          : PC loaded during reset
//   fetch_stall_i        : suppresses new requests (drain unaffected)
//   pm_rd_o/pm_addr_o    : read request and address, accepted with pm_ready_i
//   pm_instr_valid_i/_i  : in-order read response
//   instr_valid_o, instr_pc_o, next_pc_o, instr_o : queue head to decoder
//   instr_ready_i        : decoder pops the head
//   branch_pc_valid_i/_i : redirect and target
// Optional build macro INSTR_FETCH_PERF_EN adds 32-bit counters
//   perf_fetched_o, perf_dropped_o, perf_starve_o.
// -----------------------------------------------------------------------------
module instr_fetch_buf
   import fetch_pkg::*;
#(
   parameter int unsigned XLEN            = FETCH_XLEN,
   parameter int unsigned DEPTH           = 4,
   parameter int unsigned MAX_OUTSTANDING = 2
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic [XLEN-1:0] boot_addr_i,
   input  logic            fetch_stall_i,
   output logic            pm_rd_o,
   output logic [XLEN-1:0] pm_addr_o,
   input  logic            pm_ready_i,
   input  logic            pm_instr_valid_i,
   input  logic [XLEN-1:0] pm_instr_i,
   output logic            instr_valid_o,
   output logic [XLEN-1:0] instr_pc_o,
   output logic [XLEN-1:0] next_pc_o,
   output logic [XLEN-1:0] instr_o,
   input  logic            instr_ready_i,
   input  logic            branch_pc_valid_i,
   input  logic [XLEN-1:0] branch_pc_i
`ifdef INSTR_FETCH_PERF_EN
   ,
   output logic [31:0]     perf_fetched_o,
   output logic [31:0]     perf_dropped_o,
   output logic [31:0]     perf_starve_o
`endif
);

   localparam int unsigned     OW   = $clog2(MAX_OUTSTANDING+1);
   localparam int unsigned     CW   = $clog2(DEPTH+1);
   localparam logic [XLEN-1:0] STEP = XLEN'(XLEN/8);

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] next_pc;
      logic [XLEN-1:0] instr;
   } entry_t;

   logic [XLEN-1:0] fetch_pc, resp_pc;
   logic [OW-1:0]   outstanding, outstanding_n, drop;
   logic [CW-1:0]   occupancy;
   logic            fifo_full, fifo_empty, head_valid;
   logic            credit_ok, accept, keep, discard, pop_req, push_req;
   entry_t          head_data, push_data;

   // Request side: a request is only issued when its response is guaranteed
   // a queue slot, counting entries held plus responses still to be kept.
   assign credit_ok = (32'(occupancy) + 32'(outstanding) - 32'(drop)) < DEPTH;
   assign pm_rd_o   = rst_ni & ~fetch_stall_i & ~branch_pc_valid_i
                    & (32'(outstanding) < MAX_OUTSTANDING) & credit_ok;
   assign pm_addr_o = fetch_pc;
   assign accept    = pm_rd_o & pm_ready_i;

   // Response side: responses owed for pre-branch requests are swallowed.
   assign keep          = pm_instr_valid_i & (drop == '0);
   assign discard       = pm_instr_valid_i & (drop != '0);
   assign outstanding_n = outstanding + OW'(accept) - OW'(pm_instr_valid_i);

   always_comb begin
      push_data         = '0;
      push_data.pc      = resp_pc;
      push_data.next_pc = resp_pc + STEP;
      push_data.instr   = pm_instr_i;
   end

   assign pop_req  = instr_ready_i & ~fifo_empty;
   assign push_req = keep & (~fifo_full | pop_req);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         fetch_pc    <= boot_addr_i;
         resp_pc     <= boot_addr_i;
         outstanding <= '0;
         drop        <= '0;
      end else begin
         outstanding <= outstanding_n;
         if (branch_pc_valid_i) begin
            fetch_pc <= branch_pc_i;
            resp_pc  <= branch_pc_i;
            // Everything still unanswered after this cycle belongs to the
            // old path.
            drop     <= outstanding_n;
         end else begin
            if (accept)
               fetch_pc <= fetch_pc + STEP;
            if (discard)
               drop <= drop - OW'(1);
            if (keep)
               resp_pc <= resp_pc + STEP;
         end
      end
   end

   // Queue stage: registered head drives the decoder.
   fetch_fifo #(
      .entry_t (entry_t),
      .DEPTH   (DEPTH)
   ) u_fifo (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .push       (push_req),
      .push_data  (push_data),
      .pop        (pop_req),
      .flush      (branch_pc_valid_i),
      .full       (fifo_full),
      .empty      (fifo_empty),
      .occupancy  (occupancy),
      .head_valid (head_valid),
      .head_data  (head_data)
   );

   assign instr_valid_o = head_valid;
   assign instr_pc_o    = head_data.pc;
   assign next_pc_o     = head_data.next_pc;
   assign instr_o       = head_data.instr;

`ifdef INSTR_FETCH_PERF_EN
   logic kept;

   // A response arriving in a branch cycle is flushed with the queue.
   assign kept = keep & ~branch_pc_valid_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         perf_fetched_o <= '0;
         perf_dropped_o <= '0;
         perf_starve_o  <= '0;
      end else begin
         if (kept)
            perf_fetched_o <= perf_fetched_o + 32'd1;
         if (pm_instr_valid_i && !kept)
            perf_dropped_o <= perf_dropped_o + 32'd1;
         if (instr_ready_i && !head_valid)
            perf_starve_o <= perf_starve_o + 32'd1;
      end
   end
`endif

endmodule
